// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - opcode/funct encodings and memory map constants for mcu
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [31:0] GPIO_ADDR  = 32'h0000_0400;
    localparam int          IMEM_DEPTH = 256;
    localparam int          DMEM_DEPTH = 256;

endpackage

// File: rtl/mcu_inst_mem.sv
// rtl/mcu_inst_mem.sv - 256x32 instruction ROM with combinational read
module mcu_inst_mem
    import mcu_pkg::*;
(
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  raddr_i,
    output logic [31:0] rdata_o
);

    // Contents survive reset; the load port exists only for preloading and mcu ties it off.
    logic [31:0] mem_array [IMEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_array[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_array[raddr_i];

endmodule

// File: rtl/mcu.sv
// rtl/mcu.sv - single-cycle MIPS-subset core with data memory and a GPIO output word
module mcu
    import mcu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] gpio_pins
);

    logic [9:0]  pc_q, pc_d, pc_plus4;
    logic [31:0] instr;
    logic [31:0] regs_q [32];
    logic [31:0] dmem_q [DMEM_DEPTH];
    logic [31:0] gpio_q;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
    logic [29:0] word_addr;
    logic        dmem_hit, gpio_hit;
    logic [31:0] load_data;
    logic        wb_en, dmem_we, gpio_we;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;

    mcu_inst_mem inst_mem (
        .clk_i   (clk),
        .we_i    (1'b0),
        .waddr_i (8'd0),
        .wdata_i (32'd0),
        .raddr_i (pc_q[9:2]),
        .rdata_o (instr)
    );

    assign {opcode, rs, rt, rd, shamt, funct} = instr;
    assign imm      = instr[15:0];
    assign target   = instr[25:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'd0, imm};
    assign rs_val   = regs_q[rs];
    assign rt_val   = regs_q[rt];
    assign pc_plus4 = pc_q + 10'd4;

    // Byte offset bits are dropped: only whole words are addressed.
    assign word_addr = 30'((rs_val + imm_sext) >> 2);
    assign dmem_hit  = (word_addr[29:8] == '0);
    assign gpio_hit  = (word_addr == 30'(GPIO_ADDR >> 2));
    assign load_data = dmem_hit ? dmem_q[word_addr[7:0]] : (gpio_hit ? gpio_q : 32'd0);

    always_comb begin
        pc_d    = pc_plus4;
        wb_en   = 1'b0;
        wb_idx  = rt;
        wb_data = 32'd0;
        dmem_we = 1'b0;
        gpio_we = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wb_idx = rd;
                wb_en  = 1'b1;
                case (funct)
                    FN_ADD:  wb_data = rs_val + rt_val;
                    FN_SUB:  wb_data = rs_val - rt_val;
                    FN_AND:  wb_data = rs_val & rt_val;
                    FN_OR:   wb_data = rs_val | rt_val;
                    FN_SLT:  wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLL:  wb_data = rt_val << shamt;
                    FN_SRL:  wb_data = rt_val >> shamt;
                    default: wb_en   = 1'b0;
                endcase
            end
            OP_ADDI: begin wb_en = 1'b1; wb_data = rs_val + imm_sext; end
            OP_SLTI: begin wb_en = 1'b1; wb_data = {31'd0, $signed(rs_val) < $signed(imm_sext)}; end
            OP_ANDI: begin wb_en = 1'b1; wb_data = rs_val & imm_zext; end
            OP_ORI:  begin wb_en = 1'b1; wb_data = rs_val | imm_zext; end
            OP_LUI:  begin wb_en = 1'b1; wb_data = {imm, 16'd0}; end
            OP_LW:   begin wb_en = 1'b1; wb_data = load_data; end
            OP_SW:   begin dmem_we = dmem_hit; gpio_we = gpio_hit; end
            OP_BEQ:  if (rs_val == rt_val) pc_d = pc_plus4 + 10'(imm_sext << 2);
            OP_BNE:  if (rs_val != rt_val) pc_d = pc_plus4 + 10'(imm_sext << 2);
            OP_J:    pc_d = 10'({target, 2'b00});
            default: ;
        endcase
    end

    // Every architectural write lands on the same edge, so an async reset never leaves a partial commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= '0;
            gpio_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (wb_en && (wb_idx != 5'd0)) regs_q[wb_idx] <= wb_data;
            if (dmem_we) dmem_q[word_addr[7:0]] <= rt_val;
            if (gpio_we) gpio_q <= rt_val;
        end
    end

    assign gpio_pins = gpio_q;

endmodule

// File: tb/tb_mcu.sv
// tb/tb_mcu.sv - randomized and directed checks of mcu against an instruction-level model
module tb_mcu;

    logic        clk;
    logic        rst;
    logic [31:0] gpio_pins;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] prog [$];
    logic [31:0] m_imem [256];
    logic [31:0] m_dmem [256];
    logic [31:0] m_regs [32];
    logic [31:0] m_gpio;
    logic [31:0] m_pc;

    mcu dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_pins (gpio_pins)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] r_type(logic [5:0] fn, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt, logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] addr);
        if (addr < 32'h400) return m_dmem[addr[9:2]];
        if (addr < 32'h404) return m_gpio;
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_dmem[i] = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_gpio = 32'd0;
        m_pc   = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, se, ze, addr, res, npc;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, wi;
        bit          wr;
        ins  = m_imem[m_pc[9:2]];
        op   = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        sh   = ins[10:6];  fn = ins[5:0];
        se   = {{16{ins[15]}}, ins[15:0]};
        ze   = {16'd0, ins[15:0]};
        a    = m_regs[rs];
        b    = m_regs[rt];
        addr = a + se;
        npc  = (m_pc + 32'd4) % 32'd1024;
        wr   = 1'b0;
        wi   = rt;
        res  = 32'd0;
        case (op)
            6'h00: begin
                wi = rd; wr = 1'b1;
                case (fn)
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    default: wr = 1'b0;
                endcase
            end
            6'h08: begin wr = 1'b1; res = a + se; end
            6'h0A: begin wr = 1'b1; res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
            6'h0C: begin wr = 1'b1; res = a & ze; end
            6'h0D: begin wr = 1'b1; res = a | ze; end
            6'h0F: begin wr = 1'b1; res = ze << 16; end
            6'h23: begin wr = 1'b1; res = model_load(addr); end
            6'h2B: begin
                if (addr < 32'h400) m_dmem[addr[9:2]] = b;
                else if (addr < 32'h404) m_gpio = b;
            end
            6'h04: if (a == b) npc = (m_pc + 32'd4 + (se << 2)) % 32'd1024;
            6'h05: if (a != b) npc = (m_pc + 32'd4 + (se << 2)) % 32'd1024;
            6'h02: npc = ({(m_pc + 32'd4) & 32'hF000_0000} | {4'd0, ins[25:0], 2'b00}) % 32'd1024;
            default: ;
        endcase
        if (wr && wi != 5'd0) m_regs[wi] = res;
        m_pc = npc;
    endtask

    task automatic start_program();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            m_imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
            dut.inst_mem.mem_array[i] = m_imem[i];
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        prog.delete();
        prog.push_back(i_type(6'h08, 5'd0, 5'd1, 16'h00FF));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd1, 16'h0400));
        for (int i = 0; i < 256; i++) dut.inst_mem.mem_array[i] = (i < prog.size()) ? prog[i] : 32'd0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (gpio_pins !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_async: gpio_pins=%h expected 00000000", gpio_pins);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (gpio_pins !== 32'd0 || dut.pc_q !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: gpio_pins=%h pc=%h expected 0/0", c, gpio_pins, dut.pc_q);
            end
        end
    endtask

    task automatic test_gpio_basic();
        prog.delete();
        prog.push_back(i_type(6'h08, 5'd0, 5'd1, 16'h0020));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd1, 16'h0400));
        start_program();
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_cmp++;
            if (gpio_pins !== ((e >= 2) ? 32'h20 : 32'h0) || gpio_pins !== m_gpio) begin
                n_fail++;
                $display("FAIL gpio_basic edge %0d: gpio_pins=%h expected %h", e, gpio_pins, (e >= 2) ? 32'h20 : 32'h0);
            end
        end
        n_cmp++;
        if (gpio_pins[5] !== 1'b1 || gpio_pins[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL gpio_pins_5_7: pin5=%b pin7=%b expected 1/0", gpio_pins[5], gpio_pins[7]);
        end
    endtask

    task automatic test_lui_ori();
        prog.delete();
        prog.push_back(i_type(6'h0F, 5'd0, 5'd2, 16'h1234));
        prog.push_back(i_type(6'h0D, 5'd2, 5'd2, 16'h5678));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd2, 16'h0400));
        start_program();
        for (int e = 0; e < 5; e++) tick();
        n_cmp++;
        if (gpio_pins !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL lui_ori: gpio_pins=%h expected 12345678", gpio_pins);
        end
    endtask

    task automatic test_mem_roundtrip();
        prog.delete();
        prog.push_back(i_type(6'h08, 5'd0, 5'd3, 16'd5));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd3, 16'h0010));
        prog.push_back(i_type(6'h23, 5'd0, 5'd4, 16'h0010));
        prog.push_back(r_type(6'h22, 5'd5, 5'd4, 5'd3, 5'd0));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd5, 16'h0400));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd4, 16'h0400));
        start_program();
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_cmp++;
            if (gpio_pins !== ((e == 6) ? 32'd5 : 32'd0)) begin
                n_fail++;
                $display("FAIL mem_roundtrip edge %0d: gpio_pins=%h expected %h", e, gpio_pins, (e == 6) ? 32'd5 : 32'd0);
            end
        end
    endtask

    task automatic test_branch_jump();
        prog.delete();
        prog.push_back(i_type(6'h08, 5'd0, 5'd1, 16'h00FF));
        prog.push_back(i_type(6'h08, 5'd0, 5'd2, 16'h0011));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd2, 16'h0400));
        prog.push_back(i_type(6'h04, 5'd0, 5'd0, 16'h0001));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd1, 16'h0400));
        prog.push_back(j_type(26'd0));
        start_program();
        for (int e = 1; e <= 30; e++) begin
            tick();
            n_cmp++;
            if (gpio_pins === 32'hFF || gpio_pins !== m_gpio || (e >= 3 && gpio_pins !== 32'h11)) begin
                n_fail++;
                $display("FAIL branch_jump edge %0d: gpio_pins=%h expected %h", e, gpio_pins, (e >= 3) ? 32'h11 : 32'h0);
            end
        end
    endtask

    task automatic test_unmapped();
        prog.delete();
        prog.push_back(i_type(6'h08, 5'd0, 5'd1, 16'h0033));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd1, 16'h0400));
        prog.push_back(i_type(6'h08, 5'd0, 5'd2, 16'h00A5));
        prog.push_back(i_type(6'h08, 5'd0, 5'd3, 16'h007F));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd2, 16'h0800));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd2, 16'h0404));
        prog.push_back(i_type(6'h23, 5'd0, 5'd3, 16'h0800));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd3, 16'h0400));
        start_program();
        for (int e = 0; e < 6; e++) tick();
        n_cmp++;
        if (gpio_pins !== 32'h33) begin
            n_fail++;
            $display("FAIL unmapped_store: gpio_pins=%h expected 00000033", gpio_pins);
        end
        tick();
        tick();
        n_cmp++;
        if (gpio_pins !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_load: gpio_pins=%h expected 00000000", gpio_pins);
        end
    endtask

    task automatic test_async_midrun();
        prog.delete();
        prog.push_back(i_type(6'h08, 5'd0, 5'd1, 16'h0077));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd1, 16'h0020));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd1, 16'h0400));
        prog.push_back(j_type(26'd3));
        start_program();
        for (int e = 0; e < 5; e++) tick();
        n_cmp++;
        if (gpio_pins !== 32'h77) begin
            n_fail++;
            $display("FAIL midrun_pre: gpio_pins=%h expected 00000077", gpio_pins);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (gpio_pins !== 32'h0) begin
            n_fail++;
            $display("FAIL midrun_async: gpio_pins=%h expected 00000000", gpio_pins);
        end
        prog.delete();
        prog.push_back(i_type(6'h23, 5'd0, 5'd2, 16'h0020));
        prog.push_back(i_type(6'h08, 5'd2, 5'd2, 16'h0001));
        prog.push_back(r_type(6'h20, 5'd2, 5'd2, 5'd1, 5'd0));
        prog.push_back(i_type(6'h2B, 5'd0, 5'd2, 16'h0400));
        start_program();
        for (int e = 0; e < 5; e++) tick();
        n_cmp++;
        if (gpio_pins !== 32'h1) begin
            n_fail++;
            $display("FAIL reset_clears_state: gpio_pins=%h expected 00000001", gpio_pins);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  ra, rb, rc;
        logic [15:0] im;
        ra = 5'($urandom_range(0, 7));
        rb = 5'($urandom_range(1, 7));
        rc = 5'($urandom_range(0, 7));
        im = 16'($urandom);
        case ($urandom_range(0, 17))
            0:  return r_type(6'h20, rb, ra, rc, 5'd0);
            1:  return r_type(6'h22, rb, ra, rc, 5'd0);
            2:  return r_type(6'h24, rb, ra, rc, 5'd0);
            3:  return r_type(6'h25, rb, ra, rc, 5'd0);
            4:  return r_type(6'h2A, rb, ra, rc, 5'd0);
            5:  return r_type(6'h00, rb, 5'd0, rc, 5'($urandom));
            6:  return r_type(6'h02, rb, 5'd0, rc, 5'($urandom));
            7:  return i_type(6'h08, ra, rb, im);
            8:  return i_type(6'h0A, ra, rb, im);
            9:  return i_type(6'h0C, ra, rb, im);
            10: return i_type(6'h0D, ra, rb, im);
            11: return i_type(6'h0F, 5'd0, rb, im);
            12: return i_type(6'h2B, 5'd0, ra, 16'h0400 | 16'($urandom_range(0, 3)));
            13: return i_type(6'h2B, 5'd0, ra, 16'($urandom_range(0, 16'h43F)));
            14: return i_type(6'h23, ($urandom_range(0, 1) == 0) ? 5'd0 : ra, rb, 16'($urandom_range(0, 16'h43F)));
            15: return i_type(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, ra, rc, 16'($urandom_range(0, 3)));
            16: return r_type(6'h3F, rb, ra, rc, 5'd0);
            default: return {6'h3E, 26'($urandom)};
        endcase
    endfunction

    task automatic test_random();
        for (int round = 0; round < 6; round++) begin
            prog.delete();
            for (int i = 0; i < 48; i++) prog.push_back(rand_instr());
            if (round % 2 == 1) prog.push_back(j_type(26'd0));
            start_program();
            for (int e = 1; e <= 120; e++) begin
                tick();
                n_cmp++;
                if (gpio_pins !== m_gpio) begin
                    n_fail++;
                    $display("FAIL random round %0d edge %0d: gpio_pins=%h expected %h", round, e, gpio_pins, m_gpio);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_gpio_basic();
        test_lui_ori();
        test_mem_roundtrip();
        test_branch_jump();
        test_unmapped();
        test_async_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
